lcd_bus_controller: RTL

- Sequences the HD44780-style character LCD bus (lcd_data, lcd_rs, lcd_rw, lcd_enable, lcd_on) on behalf of module_mini_cpu.
- Runs the power-up init sequence itself, then accepts single-byte command/data writes over a valid/ready handshake.
- Generates all EN setup, pulse, hold and execution-wait timing in clock cycles. Write-only: lcd_rw is held at 0.

---
 rtl/lcd_bus_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lcd_bus_controller.sv
// lcd_bus_controller: HD44780-style LCD bus sequencer, power-up init plus single-byte writes
// Ports: clk, rst_n (async active-low); power_en requests power-up/init;
//   req_valid/req_rs/req_data with req_ready form the write handshake; init_done flags a usable LCD;
//   lcd_data/lcd_rs/lcd_rw/lcd_enable/lcd_on drive the panel (lcd_rw tied 0, write-only).
// Optional: define LCD_WRITE_CNT_EN to add write_count[15:0], counting completed user writes.
module lcd_bus_controller #(
  parameter int PWRUP_CYC      = 750000,
  parameter int INIT_WAIT1_CYC = 205000,
  parameter int INIT_WAIT2_CYC = 5000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2500,
  parameter int CLEAR_CYC      = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_en,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_enable,
  output logic       lcd_on
`ifdef LCD_WRITE_CNT_EN
  ,output logic [15:0] write_count
`endif
);
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
  localparam int MAXC = max2(max2(max2(PWRUP_CYC, INIT_WAIT1_CYC), max2(INIT_WAIT2_CYC, CLEAR_CYC)),
                             max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)));
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {OFF, PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE} state_t;
  function automatic logic [7:0] rom(logic [2:0] i);
    return i <= 3'd3 ? 8'h38 : i == 3'd4 ? 8'h0C : i == 3'd5 ? 8'h01 : 8'h06;
  endfunction
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, dur;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, en_q, en_d, on_q, on_d, rdy_q, rdy_d, init_q, init_d;
  logic          done, hs, clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      rdy_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= on_d;
      rdy_q   <= rdy_d;
      init_q  <= init_d;
    end
  end
  // Duration of the current timed state; the EXEC wait is chosen from the byte on the bus,
  // with the first two init commands using their longer datasheet waits.
  always_comb begin
    clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
    case (state_q)
      PWRUP:   dur = CW'(PWRUP_CYC);
      SETUP:   dur = CW'(SETUP_CYC);
      PULSE:   dur = CW'(EN_CYC);
      HOLD:    dur = CW'(HOLD_CYC);
      EXEC:    dur = (!init_q && idx_q == 3'd0) ? CW'(INIT_WAIT1_CYC) :
                     (!init_q && idx_q == 3'd1) ? CW'(INIT_WAIT2_CYC) :
                     clr ? CW'(CLEAR_CYC) : CW'(EXEC_CYC);
      default: dur = CW'(1);
    endcase
    done = cnt_q == dur - 1'b1;
  end
  // Power-off overrides every transition, including an IDLE handshake in the same cycle.
  always_comb begin
    hs = req_valid && rdy_q && power_en;
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      OFF:       state_d = PWRUP;
      PWRUP:     if (done) begin
        state_d = INIT_LOAD;
        idx_d = 3'd0;
      end
      INIT_LOAD: state_d = SETUP;
      SETUP:     if (done) state_d = PULSE;
      PULSE:     if (done) state_d = HOLD;
      HOLD:      if (done) state_d = EXEC;
      EXEC:      if (done) begin
        if (init_q || idx_q == 3'd6) state_d = IDLE;
        else begin
          state_d = INIT_LOAD;
          idx_d = idx_q + 3'd1;
        end
      end
      IDLE:      if (hs) state_d = SETUP;
      default:   state_d = OFF;
    endcase
    if (!power_en) state_d = OFF;
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
  end
  // Outputs are computed from the next state so the registered bus lines up with it.
  always_comb begin
    on_d   = state_d != OFF;
    en_d   = state_d == PULSE;
    rdy_d  = state_d == IDLE;
    init_d = state_d == OFF ? 1'b0 : (state_q == EXEC && state_d == IDLE) || init_q;
    data_d = state_d == OFF ? 8'h00 : state_d == INIT_LOAD ? rom(idx_d) : hs ? req_data : data_q;
    rs_d   = (state_d == OFF || state_d == INIT_LOAD) ? 1'b0 : hs ? req_rs : rs_q;
  end
  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_enable = en_q;
  assign lcd_on     = on_q;
  assign req_ready  = rdy_q;
  assign init_done  = init_q;
`ifdef LCD_WRITE_CNT_EN
  logic [15:0] wc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wc_q <= '0;
    else if (state_d == OFF) wc_q <= '0;
    else if (state_q == EXEC && state_d == IDLE && init_q) wc_q <= wc_q + 16'd1;
  end
  assign write_count = wc_q;
`endif
endmodule
